// File: rtl/arf_access_sequencer.sv
// Control sequencer for address-register-file memory commands (FETCH/PUSH/POP/LOAD_AR).
// Moore FSM with a bounded MemReady wait; the state is exposed on o_state for checkers.
module arf_access_sequencer #(
  parameter int TIMEOUT = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [1:0] i_op,
  input  logic       i_mem_ready,
  output logic [2:0] o_fun_sel,
  output logic [2:0] o_reg_sel,
  output logic [1:0] o_out_c_sel,
  output logic [1:0] o_out_d_sel,
  output logic       o_mem_read,
  output logic       o_mem_write,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_timeout,
  output logic [2:0] o_state
);

  localparam logic [1:0] OP_FETCH = 2'b00;
  localparam logic [1:0] OP_PUSH  = 2'b01;
  localparam logic [1:0] OP_POP   = 2'b10;
  localparam logic [1:0] OP_LOAD  = 2'b11;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_MEM  = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [1:0]      r_op;
  logic [CW-1:0]   r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Op is latched only on acceptance; the wait counter runs only while in MEM.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_op  <= OP_FETCH;
      r_cnt <= '0;
    end else begin
      if (r_state == S_IDLE && i_start) r_op <= i_op;
      if (r_state != S_MEM)             r_cnt <= '0;
      else if (!i_mem_ready)            r_cnt <= r_cnt + CW'(1);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          case (i_op)
            OP_POP:  w_next = S_PRE;
            OP_LOAD: w_next = S_POST;
            default: w_next = S_MEM;
          endcase
        end
      end
      S_PRE:  w_next = S_MEM;
      // MemReady wins over the timeout when both land on the same cycle.
      S_MEM: begin
        if (i_mem_ready)         w_next = (r_op == OP_POP) ? S_DONE : S_POST;
        else if (r_cnt == LIMIT) w_next = S_ERR;
      end
      S_POST: w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      S_ERR:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_fun_sel   = 3'b000;
    o_reg_sel   = 3'b111;
    o_out_c_sel = 2'b00;
    o_out_d_sel = 2'b00;
    o_mem_read  = 1'b0;
    o_mem_write = 1'b0;
    o_done      = 1'b0;
    o_timeout   = 1'b0;
    o_busy      = (r_state != S_IDLE);
    o_state     = r_state;
    case (r_state)
      S_PRE: begin
        o_reg_sel = 3'b110;
        o_fun_sel = 3'b001;
      end
      S_MEM: begin
        case (r_op)
          OP_PUSH: begin
            o_out_d_sel = 2'b11;
            o_mem_write = 1'b1;
          end
          OP_POP: begin
            o_out_d_sel = 2'b11;
            o_mem_read  = 1'b1;
          end
          default: o_mem_read = 1'b1;
        endcase
      end
      S_POST: begin
        case (r_op)
          OP_FETCH: begin
            o_reg_sel = 3'b011;
            o_fun_sel = 3'b001;
          end
          OP_PUSH: begin
            o_reg_sel = 3'b110;
            o_fun_sel = 3'b000;
          end
          OP_LOAD: begin
            o_reg_sel = 3'b101;
            o_fun_sel = 3'b010;
          end
          default: ;
        endcase
      end
      S_DONE: o_done    = 1'b1;
      S_ERR:  o_timeout = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_arf_access_sequencer.sv
// Bench for arf_access_sequencer: a command-level model expands each command into its
// per-cycle output vectors, and a compare process checks the DUT against them every cycle.
module tb_arf_access_sequencer;

  localparam int TO = 16;
  localparam int W  = 15;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] op;
  logic       ready;
  logic [2:0] fun_sel;
  logic [2:0] reg_sel;
  logic [1:0] out_c_sel;
  logic [1:0] out_d_sel;
  logic       mem_read;
  logic       mem_write;
  logic       busy;
  logic       done;
  logic       timeout;
  logic [2:0] state;

  arf_access_sequencer #(.TIMEOUT(TO)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_op        (op),
    .i_mem_ready (ready),
    .o_fun_sel   (fun_sel),
    .o_reg_sel   (reg_sel),
    .o_out_c_sel (out_c_sel),
    .o_out_d_sel (out_d_sel),
    .o_mem_read  (mem_read),
    .o_mem_write (mem_write),
    .o_busy      (busy),
    .o_done      (done),
    .o_timeout   (timeout),
    .o_state     (state)
  );

  // Packed view: {busy, done, timeout, mem_read, mem_write, reg_sel, fun_sel, out_c, out_d}
  logic [W-1:0] dut_vec;
  assign dut_vec = {busy, done, timeout, mem_read, mem_write, reg_sel, fun_sel, out_c_sel, out_d_sel};

  logic [W-1:0] exp_q[$];
  logic [W-1:0] tr[$];
  int n_checks = 0;
  int n_errors = 0;
  int cnt_mr, cnt_mw, cnt_done, cnt_to, cnt_upd, cnt_pre;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  function automatic logic [W-1:0] mk(input logic b, input logic d, input logic t,
                                      input logic mr, input logic mw,
                                      input logic [2:0] rs, input logic [2:0] fs,
                                      input logic [1:0] ds);
    return {b, d, t, mr, mw, rs, fs, 2'b00, ds};
  endfunction

  function automatic logic [W-1:0] v_idle();
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b111, 3'b000, 2'b00);
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- scoreboard compare ----------------
  initial begin
    logic [W-1:0] e;
    forever begin
      @(posedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("cycle", dut_vec, e);
      end
    end
  end

  // ---------------- model: command -> per-cycle outputs after each edge ----------------
  task automatic model_cmd(input logic [1:0] c_op, input int w, output int n, output int mem_first);
    logic [W-1:0] mem_v;
    logic [W-1:0] seq[$];
    seq = {};
    mem_first = -1;
    if (c_op == 2'b11) begin
      seq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b101, 3'b010, 2'b00));
    end else begin
      if (c_op == 2'b10) seq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b110, 3'b001, 2'b00));
      mem_first = (c_op == 2'b10) ? 2 : 1;
      case (c_op)
        2'b00:   mem_v = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b111, 3'b000, 2'b00);
        2'b01:   mem_v = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b111, 3'b000, 2'b11);
        default: mem_v = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b111, 3'b000, 2'b11);
      endcase
      if (w < 0) begin
        for (int i = 0; i < TO; i++) seq.push_back(mem_v);
        seq.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b111, 3'b000, 2'b00));
      end else begin
        for (int i = 0; i <= w; i++) seq.push_back(mem_v);
        if (c_op == 2'b00) seq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b011, 3'b001, 2'b00));
        if (c_op == 2'b01) seq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b110, 3'b000, 2'b00));
      end
    end
    if (!(c_op != 2'b11 && w < 0)) seq.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b111, 3'b000, 2'b00));
    seq.push_back(v_idle());
    n = seq.size();
    foreach (seq[i]) exp_q.push_back(seq[i]);
  endtask

  // ---------------- driver: called #1 after an edge with the DUT idle ----------------
  // w = number of MemReady=0 cycles in MEM before MemReady=1; w < 0 means never ready.
  task automatic run_cmd(input logic [1:0] c_op, input int w, input logic hold);
    int n;
    int mf;
    logic in_mem;
    model_cmd(c_op, w, n, mf);
    tr = {};
    for (int c = 0; c < n; c++) begin
      tr.push_back(dut_vec);
      if (c == 0) begin
        start = 1'b1;
        op    = c_op;
      end else begin
        start = hold ? 1'b1 : 1'(($urandom_range(0, 1)));
        op    = 2'($urandom_range(0, 3));
      end
      in_mem = (mf >= 0) && (c >= mf) && ((w < 0) ? (c < mf + TO) : (c <= mf + w));
      if (in_mem) ready = (w >= 0) && (c == mf + w);
      else        ready = 1'(($urandom_range(0, 1)));
      @(posedge clk);
      #1;
    end
    tr.push_back(dut_vec);
    if (!hold) start = 1'b0;
  endtask

  task automatic summarize();
    cnt_mr = 0; cnt_mw = 0; cnt_done = 0; cnt_to = 0; cnt_upd = 0; cnt_pre = 0;
    foreach (tr[i]) begin
      logic [W-1:0] v;
      v = tr[i];
      if (v[11]) cnt_mr++;
      if (v[10]) cnt_mw++;
      if (v[13]) cnt_done++;
      if (v[12]) cnt_to++;
      if (v[9:7] != 3'b111) cnt_upd++;
      if (v[9:7] == 3'b110 && v[6:4] == 3'b001) cnt_pre++;
    end
  endtask

  function automatic logic [W-1:0] tr_at(input int i);
    return tr[i];
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    logic [W-1:0] v;
    rst = 1'b0; start = 1'b0; op = 2'b00; ready = 1'b0;
    #1 rst = 1'b1;
    #1 check("reset_async_defaults", dut_vec, v_idle());
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    exp_q.push_back(v_idle());

    // LOAD_AR: POST at cycle 1, Done at 2, idle at 3
    run_cmd(2'b11, 0, 1'b0);
    v = tr_at(1); check_int("load_regsel", int'(v[9:7]), 5);
    check_int("load_funsel", int'(v[6:4]), 2);
    v = tr_at(2); check_int("load_done", int'(v[13]), 1);
    v = tr_at(3); check_int("load_busy_low", int'(v[14]), 0);

    // FETCH with MemReady immediately
    run_cmd(2'b00, 0, 1'b0);
    v = tr_at(1); check_int("fetch_memread", int'(v[11]), 1);
    check_int("fetch_dsel", int'(v[1:0]), 0);
    v = tr_at(2); check_int("fetch_regsel", int'(v[9:7]), 3);
    check_int("fetch_funsel", int'(v[6:4]), 1);
    v = tr_at(3); check_int("fetch_done", int'(v[13]), 1);

    // POP, ready on the 3rd MEM cycle
    run_cmd(2'b10, 2, 1'b0);
    summarize();
    check_int("pop_pre_once", cnt_pre, 1);
    check_int("pop_mem_cycles", cnt_mr, 3);
    check_int("pop_no_post", cnt_upd, 1);
    v = tr_at(5); check_int("pop_done", int'(v[13]), 1);

    // PUSH timeout
    run_cmd(2'b01, -1, 1'b0);
    summarize();
    check_int("push_to_mw_cycles", cnt_mw, TO);
    check_int("push_to_pulse", cnt_to, 1);
    check_int("push_to_no_done", cnt_done, 0);
    check_int("push_to_no_update", cnt_upd, 0);
    v = tr_at(TO + 1); check_int("push_to_at", int'(v[12]), 1);

    // More patterns: PUSH with waits, POP immediate, FETCH ready exactly at the limit, POP timeout
    run_cmd(2'b01, 3, 1'b0);
    run_cmd(2'b10, 0, 1'b0);
    run_cmd(2'b00, TO - 1, 1'b0);
    summarize();
    check_int("fetch_limit_no_to", cnt_to, 0);
    check_int("fetch_limit_done", cnt_done, 1);
    run_cmd(2'b10, -1, 1'b0);
    summarize();
    check_int("pop_to_pre_kept", cnt_pre, 1);
    check_int("pop_to_pulse", cnt_to, 1);

    // Reset during MEM of a FETCH
    start = 1'b1; op = 2'b00; ready = 1'b0;
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b111, 3'b000, 2'b00));
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1 check("reset_mid_mem", dut_vec, v_idle());
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.push_back(v_idle());
    run_cmd(2'b11, 0, 1'b0);
    v = tr_at(2); check_int("after_reset_load_done", int'(v[13]), 1);

    // Start held high through a FETCH, then back-to-back LOAD_AR
    run_cmd(2'b00, 1, 1'b1);
    run_cmd(2'b11, 0, 1'b0);

    repeat (3) begin
      exp_q.push_back(v_idle());
      @(posedge clk); #1;
    end
    @(posedge clk); #4;
    check_int("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/arf_access_sequencer.md
ARF_ACCESS_SEQUENCER -- requirements
Module: arf_access_sequencer

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16, giving the maximum number of MEM-state cycles to wait for MemReady.
REQ-002 Clock  input  1  single clock; all state updates on its rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 Start  input  1  command request, sampled only in IDLE.
REQ-005 Op  input  2  command: 00 FETCH, 01 PUSH, 10 POP, 11 LOAD_AR.
REQ-006 MemReady  input  1  memory completion for the current MemRead/MemWrite access.
REQ-007 FunSel  output  3  address-register function: 000 decrement, 001 increment, 010 load I, 011 clear.
REQ-008 RegSel  output  3  active-low register enables: bit2 PC, bit1 AR, bit0 SP; 111 means all hold.
REQ-009 OutCSel  output  2  C-port select: 00 PC, 10 AR, 11 SP.
REQ-010 OutDSel  output  2  D-port (memory address) select, same encoding as OutCSel.
REQ-011 MemRead  output  1  memory read request.
REQ-012 MemWrite  output  1  memory write request.
REQ-013 Busy  output  1  high in every state except IDLE.
REQ-014 Done  output  1  one-cycle pulse on successful command completion.
REQ-015 Timeout  output  1  one-cycle pulse on an aborted memory access.

Function
REQ-016 The FSM SHALL have states IDLE, PRE, MEM, POST, DONE and ERR, and all outputs SHALL be Moore (decoded from the registered state and the latched Op only).
REQ-017 Idle defaults SHALL be RegSel=111, FunSel=000, OutCSel=00, OutDSel=00, MemRead=0, MemWrite=0, Done=0, Timeout=0.
REQ-018 In IDLE with Start=1, the block SHALL latch Op and go to PRE for POP, POST for LOAD_AR, and MEM for FETCH or PUSH.
REQ-019 Start SHALL be ignored outside IDLE, and the latched Op SHALL NOT change until the next IDLE.
REQ-020 PRE (POP only, 1 cycle): RegSel=110, FunSel=001 (SP increment); then go to MEM.
REQ-021 MEM: OutDSel=00 (PC) with MemRead=1 for FETCH; OutDSel=11 (SP) with MemWrite=1 for PUSH; OutDSel=11 with MemRead=1 for POP; RegSel=111 throughout.
REQ-022 In MEM, MemReady=1 SHALL exit the state on that edge: to POST for FETCH and PUSH, and to DONE for POP.
REQ-023 A wait counter SHALL clear on MEM entry and increment each MEM cycle with MemReady=0.
REQ-024 When the counter equals TIMEOUT-1 and MemReady=0, the next state SHALL be ERR.
REQ-025 MemReady=1 on the same cycle as the counter limit SHALL take precedence over the timeout.
REQ-026 POST (1 cycle): FETCH gives RegSel=011, FunSel=001 (PC+1); PUSH gives RegSel=110, FunSel=000 (SP-1); LOAD_AR gives RegSel=101, FunSel=010 (AR<=I); then go to DONE.
REQ-027 DONE SHALL assert Done=1 for one cycle, then go to IDLE.
REQ-028 ERR SHALL assert Timeout=1 for one cycle, issue no register update, then go to IDLE.
REQ-029 A POP pre-increment that is already applied SHALL NOT be undone on timeout.
REQ-030 Latency from the Start edge to Done SHALL be: LOAD_AR 2 cycles; FETCH/PUSH 3+w cycles; POP 3+w cycles, where w is the number of MemReady=0 wait cycles.
REQ-031 MemRead and MemWrite SHALL never be high together, and RegSel SHALL be 111 in every state except PRE and POST.
REQ-032 MemReady outside MEM SHALL be ignored.

Reset
REQ-033 Reset=1 SHALL immediately force IDLE, clear the wait counter and latched Op, and drive all outputs to the REQ-017 defaults with Busy=0, without waiting for Clock.
REQ-034 Reset asserted mid-command SHALL abandon the command with no further register update and no Done or Timeout pulse.

Verification
REQ-035 LOAD_AR: Start=1, Op=11 at cycle 0 -> cycle 1 RegSel=101, FunSel=010; cycle 2 Done=1; cycle 3 Busy=0.
REQ-036 FETCH, MemReady tied high: Start at cycle 0 -> cycle 1 MemRead=1, OutDSel=00; cycle 2 RegSel=011, FunSel=001; cycle 3 Done=1.
REQ-037 POP, MemReady high on the 3rd MEM cycle -> PRE SP+1 once, MEM held 3 cycles with OutDSel=11 and MemRead=1, Done on the next cycle, no POST update.
REQ-038 PUSH, MemReady held low, TIMEOUT=16 -> MemWrite high for exactly 16 cycles, then Timeout=1 for one cycle, no SP decrement, Done never asserted.
REQ-039 Reset pulsed during MEM of a FETCH -> outputs reach defaults asynchronously, and a new Start=1 with Op=11 after release completes normally.
REQ-040 Start held high through a whole FETCH -> a second command starts only from IDLE, and no Op change is taken mid-command.
